// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg
//   Shared definitions for the two-master IO bus arbiter.
//   - state_t          : arbiter FSM state encoding (IDLE, ADDR, DATA)
//   - MAX_HOLD_DEFAULT : default limit on consecutive locked transfers
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam int unsigned MAX_HOLD_DEFAULT = 16;

endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if
//   Bundles both masters' request/response signals and the IO-bus side.
//   modport slave  : arbiter view (takes master requests and s_rdata,
//                    drives gnt/ack/rdata and s_addr/s_we/s_wdata)
//   modport master : environment view (masters plus IO-bus memory)
interface bus_arbiter_if;

    logic        m0_req;
    logic [31:0] m0_addr;
    logic        m0_we;
    logic [31:0] m0_wdata;
    logic        m0_lock;
    logic        m0_gnt;
    logic        m0_ack;
    logic [31:0] m0_rdata;

    logic        m1_req;
    logic [31:0] m1_addr;
    logic        m1_we;
    logic [31:0] m1_wdata;
    logic        m1_lock;
    logic        m1_gnt;
    logic        m1_ack;
    logic [31:0] m1_rdata;

    logic [31:0] s_addr;
    logic        s_we;
    logic [31:0] s_wdata;
    logic [31:0] s_rdata;

    modport slave (
        input  m0_req, m0_addr, m0_we, m0_wdata, m0_lock,
        input  m1_req, m1_addr, m1_we, m1_wdata, m1_lock,
        input  s_rdata,
        output m0_gnt, m0_ack, m0_rdata,
        output m1_gnt, m1_ack, m1_rdata,
        output s_addr, s_we, s_wdata
    );

    modport master (
        output m0_req, m0_addr, m0_we, m0_wdata, m0_lock,
        output m1_req, m1_addr, m1_we, m1_wdata, m1_lock,
        output s_rdata,
        input  m0_gnt, m0_ack, m0_rdata,
        input  m1_gnt, m1_ack, m1_rdata,
        input  s_addr, s_we, s_wdata
    );

endinterface

// File: rtl/bus_arb_pick.sv
// bus_arb_pick
//   Combinational winner select between two requesters.
//   Ports: req0, req1    - master requests
//          last_served   - master that completed the most recent transfer
//          valid         - at least one request present
//          winner        - selected master (0/1), meaningful when valid
//   Macro BUS_ARBITER_RR_EN: defined -> round-robin on ties (the master
//   not last served wins); undefined -> fixed priority, master 0 wins ties.
module bus_arb_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_served,
    output logic valid,
    output logic winner
);

`ifndef BUS_ARBITER_RR_EN
    // last_served is still tracked by the arbiter but ignored here.
    logic unused_last_served;
    assign unused_last_served = last_served;
`endif

    always_comb begin
        valid  = req0 | req1;
        winner = 1'b0;
        if (req0 && req1) begin
`ifdef BUS_ARBITER_RR_EN
            winner = ~last_served;
`else
            winner = 1'b0;
`endif
        end else begin
            winner = req1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Two-master arbiter for a synchronous IO bus. Each transfer takes two
//   cycles: ADDR drives the owner's address/write onto the bus, DATA returns
//   s_rdata and pulses the owner's ack. A master holding lock may keep the
//   bus for up to MAX_HOLD consecutive transfers.
//   Ports: clk  - system clock
//          rst  - asynchronous active-low reset
//          bus  - bus_arbiter_if.slave (both masters + IO-bus signals)
//   Macro BUS_ARBITER_RR_EN selects round-robin tie-break (see bus_arb_pick).
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    bus_arbiter_if.slave bus
);

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    state_t      state;
    logic        owner;
    logic        last_served;
    logic [7:0]  hold_cnt;
    logic        gnt0, gnt1;
    logic        ack0, ack1;
    logic [31:0] rdata0_q, rdata1_q;

    logic        own_req, own_lock;
    logic        pick_last, pick_valid, pick_winner;

    assign own_req  = owner ? bus.m1_req  : bus.m0_req;
    assign own_lock = owner ? bus.m1_lock : bus.m0_lock;

    // Leaving DATA, last_served is updated to owner on the same edge, so the
    // tie-break must already see the current owner as the last served.
    assign pick_last = (state == DATA) ? owner : last_served;

    bus_arb_pick u_pick (
        .req0        (bus.m0_req),
        .req1        (bus.m1_req),
        .last_served (pick_last),
        .valid       (pick_valid),
        .winner      (pick_winner)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_served <= 1'b1;
            hold_cnt    <= '0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner    <= pick_winner;
                        hold_cnt <= 8'd1;
                        gnt0     <= ~pick_winner;
                        gnt1     <= pick_winner;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    ack0  <= ~owner;
                    ack1  <= owner;
                    state <= DATA;
                end
                DATA: begin
                    ack0        <= 1'b0;
                    ack1        <= 1'b0;
                    last_served <= owner;
                    if (owner) rdata1_q <= bus.s_rdata;
                    else       rdata0_q <= bus.s_rdata;
                    if (own_req && own_lock && (hold_cnt < HOLD_LIMIT)) begin
                        hold_cnt <= hold_cnt + 8'd1;
                        state    <= ADDR;
                    end else if (pick_valid) begin
                        owner    <= pick_winner;
                        hold_cnt <= 8'd1;
                        gnt0     <= ~pick_winner;
                        gnt1     <= pick_winner;
                        state    <= ADDR;
                    end else begin
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Bus side is driven only during ADDR; zero otherwise.
    always_comb begin
        bus.s_addr  = '0;
        bus.s_we    = 1'b0;
        bus.s_wdata = '0;
        if (state == ADDR) begin
            bus.s_addr  = owner ? bus.m1_addr  : bus.m0_addr;
            bus.s_we    = owner ? bus.m1_we    : bus.m0_we;
            bus.s_wdata = owner ? bus.m1_wdata : bus.m0_wdata;
        end
    end

    assign bus.m0_gnt = gnt0;
    assign bus.m1_gnt = gnt1;
    assign bus.m0_ack = ack0;
    assign bus.m1_ack = ack1;

    // s_rdata is only valid during DATA; pass it through while ack is high
    // and present the captured copy afterwards.
    assign bus.m0_rdata = ack0 ? bus.s_rdata : rdata0_q;
    assign bus.m1_rdata = ack1 ? bus.s_rdata : rdata1_q;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

    localparam int unsigned MAXH = 4;

    logic clk = 1'b0;
    logic rst;

    bus_arbiter_if bus ();

    bus_arbiter #(.MAX_HOLD(MAXH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Transfer-level reference model: a transfer occupies two bus slots
    // (slot 1 = address phase, slot 2 = data phase); slot 0 = bus free.
    int          m_slot;
    bit          m_owner;
    bit          m_last;
    int          m_burst;
    logic [31:0] m_held [2];

    task automatic idle_inputs();
        bus.m0_req = 0; bus.m0_addr = '0; bus.m0_we = 0; bus.m0_wdata = '0; bus.m0_lock = 0;
        bus.m1_req = 0; bus.m1_addr = '0; bus.m1_we = 0; bus.m1_wdata = '0; bus.m1_lock = 0;
        bus.s_rdata = '0;
    endtask

    task automatic model_reset();
        m_slot = 0; m_owner = 0; m_last = 1; m_burst = 0;
        m_held[0] = '0; m_held[1] = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1;
        model_reset();
    endtask

    function automatic bit choose(bit r0, bit r1);
        if (r0 && r1) begin
`ifdef BUS_ARBITER_RR_EN
            return !m_last;
`else
            return 1'b0;
`endif
        end
        return r1;
    endfunction

    task automatic model_step();
        bit r [2];
        bit l [2];
        r[0] = bus.m0_req;  r[1] = bus.m1_req;
        l[0] = bus.m0_lock; l[1] = bus.m1_lock;
        if (m_slot == 0) begin
            if (r[0] || r[1]) begin
                m_owner = choose(r[0], r[1]); m_burst = 1; m_slot = 1;
            end
        end else if (m_slot == 1) begin
            m_slot = 2;
        end else begin
            m_held[m_owner] = bus.s_rdata;
            m_last = m_owner;
            if (r[m_owner] && l[m_owner] && m_burst < int'(MAXH)) begin
                m_burst++; m_slot = 1;
            end else if (r[0] || r[1]) begin
                m_owner = choose(r[0], r[1]); m_burst = 1; m_slot = 1;
            end else begin
                m_slot = 0;
            end
        end
    endtask

    task automatic set_master(int unsigned i, bit req, logic [31:0] addr, bit we,
                              logic [31:0] wdata, bit lock);
        if (i == 0) begin
            bus.m0_req = req; bus.m0_addr = addr; bus.m0_we = we; bus.m0_wdata = wdata; bus.m0_lock = lock;
        end else begin
            bus.m1_req = req; bus.m1_addr = addr; bus.m1_we = we; bus.m1_wdata = wdata; bus.m1_lock = lock;
        end
    endtask

    task automatic test_reset();
        logic [3:0]  ctl;
        logic [64:0] sb;
        idle_inputs();
        rst = 0;
        #1;
        ctl = {bus.m0_gnt, bus.m1_gnt, bus.m0_ack, bus.m1_ack};
        sb  = {bus.s_addr, bus.s_we, bus.s_wdata};
        total++; if (ctl !== 4'b0) begin bad++; $display("FAIL reset_ctl: got %b want 0000", ctl); end
        total++; if (bus.m0_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata0: got %h want 0", bus.m0_rdata); end
        total++; if (bus.m1_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata1: got %h want 0", bus.m1_rdata); end
        total++; if (sb !== 65'h0) begin bad++; $display("FAIL reset_sbus: got %h want 0", sb); end
        bus.m0_req = 1;
        bus.m0_addr = 32'h44;
        @(posedge clk); #1;
        total++; if (bus.m0_gnt !== 1'b0) begin bad++; $display("FAIL reset_hold_gnt: got %b want 0", bus.m0_gnt); end
        idle_inputs();
    endtask

    task automatic test_read();
        set_master(0, 1, 32'h00000010, 0, 32'h0, 0);
        @(negedge clk);
        total++; if ({bus.m0_gnt, bus.m0_ack, bus.m1_gnt} !== 3'b100) begin bad++; $display("FAIL read_addr_ctl: got %b want 100", {bus.m0_gnt, bus.m0_ack, bus.m1_gnt}); end
        total++; if ({bus.s_addr, bus.s_we} !== {32'h00000010, 1'b0}) begin bad++; $display("FAIL read_saddr: got %h/%b want 00000010/0", bus.s_addr, bus.s_we); end
        bus.s_rdata = 32'h12345678;
        @(negedge clk);
        total++; if ({bus.m0_gnt, bus.m0_ack, bus.m1_gnt, bus.m1_ack} !== 4'b1100) begin bad++; $display("FAIL read_data_ctl: got %b want 1100", {bus.m0_gnt, bus.m0_ack, bus.m1_gnt, bus.m1_ack}); end
        total++; if (bus.m0_rdata !== 32'h12345678) begin bad++; $display("FAIL read_rdata: got %h want 12345678", bus.m0_rdata); end
        total++; if (bus.s_addr !== 32'h0) begin bad++; $display("FAIL read_saddr_data: got %h want 0", bus.s_addr); end
        bus.m0_req = 0;
        @(negedge clk);
        bus.s_rdata = 32'hDEADDEAD;
        #1;
        total++; if ({bus.m0_gnt, bus.m0_ack} !== 2'b00) begin bad++; $display("FAIL read_idle_ctl: got %b want 00", {bus.m0_gnt, bus.m0_ack}); end
        total++; if (bus.m0_rdata !== 32'h12345678) begin bad++; $display("FAIL read_rdata_hold: got %h want 12345678", bus.m0_rdata); end
        total++; if (bus.m1_rdata !== 32'h0) begin bad++; $display("FAIL read_m1_rdata: got %h want 0", bus.m1_rdata); end
    endtask

    task automatic test_write();
        int unsigned we_cnt = 0;
        logic [31:0] a_seen = '0;
        logic [31:0] d_seen = '0;
        set_master(0, 1, 32'hf0000004, 1, 32'hCAFEBABE, 0);
        bus.s_rdata = 32'h0BAD0BAD;
        for (int unsigned i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.s_we === 1'b1) begin
                we_cnt++; a_seen = bus.s_addr; d_seen = bus.s_wdata;
            end
            if (bus.m0_ack === 1'b1) bus.m0_req = 0;
        end
        total++; if (we_cnt != 1) begin bad++; $display("FAIL write_we_cycles: got %0d want 1", we_cnt); end
        total++; if (a_seen !== 32'hf0000004) begin bad++; $display("FAIL write_addr: got %h want f0000004", a_seen); end
        total++; if (d_seen !== 32'hCAFEBABE) begin bad++; $display("FAIL write_wdata: got %h want cafebabe", d_seen); end
        total++; if (bus.m0_rdata !== 32'h0BAD0BAD) begin bad++; $display("FAIL write_rdata_load: got %h want 0bad0bad", bus.m0_rdata); end
        idle_inputs();
    endtask

    task automatic test_drop();
        set_master(0, 1, 32'h00000020, 0, 32'h0, 0);
        @(negedge clk);
        total++; if (bus.m0_gnt !== 1'b1) begin bad++; $display("FAIL drop_gnt: got %b want 1", bus.m0_gnt); end
        bus.m0_req = 0;
        @(negedge clk);
        total++; if (bus.m0_ack !== 1'b1) begin bad++; $display("FAIL drop_ack: got %b want 1", bus.m0_ack); end
        @(negedge clk);
        total++; if ({bus.m0_gnt, bus.m0_ack, bus.s_addr} !== 34'h0) begin bad++; $display("FAIL drop_idle: got %h want 0", {bus.m0_gnt, bus.m0_ack, bus.s_addr}); end
        idle_inputs();
    endtask

    task automatic test_lock_hold();
        int m1_acks = 0;
        int last_m1 = -1;
        int m0_at   = -1;
        set_master(1, 1, 32'h00000100, 0, 32'h0, 1);
        @(negedge clk);
        total++; if (bus.m1_gnt !== 1'b1) begin bad++; $display("FAIL lock_first_gnt: got %b want 1", bus.m1_gnt); end
        set_master(0, 1, 32'h00000200, 0, 32'h0, 0);
        for (int i = 0; i < 30 && m0_at < 0; i++) begin
            @(negedge clk);
            if (bus.m1_ack === 1'b1) begin m1_acks++; last_m1 = i; end
            if (bus.m0_ack === 1'b1) begin m0_at = i; idle_inputs(); end
        end
        total++; if (m1_acks != int'(MAXH)) begin bad++; $display("FAIL lock_m1_acks: got %0d want %0d", m1_acks, MAXH); end
        total++; if (m0_at - last_m1 != 2) begin bad++; $display("FAIL lock_handover: got %0d want 2", m0_at - last_m1); end
        idle_inputs();
        @(negedge clk);
        total++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b00) begin bad++; $display("FAIL lock_release: got %b want 00", {bus.m0_gnt, bus.m1_gnt}); end
    endtask

    task automatic test_alternate();
        int owners [$];
        bit exp;
        do_reset();
        set_master(0, 1, 32'h00000300, 0, 32'h0, 0);
        set_master(1, 1, 32'h00000400, 0, 32'h0, 0);
        for (int i = 0; i < 40 && owners.size() < 8; i++) begin
            @(negedge clk);
            if (bus.m0_ack === 1'b1) owners.push_back(0);
            if (bus.m1_ack === 1'b1) owners.push_back(1);
        end
        idle_inputs();
        total++; if (owners.size() != 8) begin bad++; $display("FAIL alt_count: got %0d want 8", owners.size()); end
        foreach (owners[k]) begin
`ifdef BUS_ARBITER_RR_EN
            exp = (k % 2) == 1;
`else
            exp = 1'b0;
`endif
            total++; if (owners[k] != int'(exp)) begin bad++; $display("FAIL alt_owner[%0d]: got %0d want %0d", k, owners[k], exp); end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        set_master(1, 1, 32'h000000A0, 1, 32'h55AA55AA, 0);
        @(negedge clk);
        total++; if ({bus.m1_gnt, bus.s_we} !== 2'b11) begin bad++; $display("FAIL rmid_addr: got %b want 11", {bus.m1_gnt, bus.s_we}); end
        #2 rst = 0;
        #1;
        total++; if ({bus.s_we, bus.m1_gnt, bus.m1_ack} !== 3'b000) begin bad++; $display("FAIL rmid_async: got %b want 000", {bus.s_we, bus.m1_gnt, bus.m1_ack}); end
        @(negedge clk);
        total++; if ({bus.m1_ack, bus.m0_gnt, bus.m1_gnt} !== 3'b000) begin bad++; $display("FAIL rmid_noack: got %b want 000", {bus.m1_ack, bus.m0_gnt, bus.m1_gnt}); end
        set_master(0, 1, 32'h000000B0, 0, 32'h0, 0);
        rst = 1;
        @(negedge clk);
        total++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10) begin bad++; $display("FAIL rmid_tie: got %b want 10", {bus.m0_gnt, bus.m1_gnt}); end
        idle_inputs();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        bit          busy [2];
        bit          eg [2];
        bit          ea [2];
        logic [31:0] er [2];
        logic [64:0] es;
        busy[0] = 0; busy[1] = 0;
        do_reset();
        for (int unsigned c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int unsigned i = 0; i < 2; i++) begin
                eg[i] = (m_slot != 0) && (m_owner == i[0]);
                ea[i] = (m_slot == 2) && (m_owner == i[0]);
                er[i] = ea[i] ? bus.s_rdata : m_held[i];
            end
            if (m_slot == 1)
                es = m_owner ? {bus.m1_addr, bus.m1_we, bus.m1_wdata} : {bus.m0_addr, bus.m0_we, bus.m0_wdata};
            else
                es = '0;
            total++;
            if ({bus.m0_gnt, bus.m1_gnt, bus.m0_ack, bus.m1_ack} !== {eg[0], eg[1], ea[0], ea[1]}) begin
                bad++; $display("FAIL rand_ctl @%0d: got %b want %b", c,
                    {bus.m0_gnt, bus.m1_gnt, bus.m0_ack, bus.m1_ack}, {eg[0], eg[1], ea[0], ea[1]});
            end
            total++;
            if ({bus.m0_rdata, bus.m1_rdata} !== {er[0], er[1]}) begin
                bad++; $display("FAIL rand_rdata @%0d: got %h %h want %h %h", c, bus.m0_rdata, bus.m1_rdata, er[0], er[1]);
            end
            total++;
            if ({bus.s_addr, bus.s_we, bus.s_wdata} !== es) begin
                bad++; $display("FAIL rand_sbus @%0d: got %h want %h", c, {bus.s_addr, bus.s_we, bus.s_wdata}, es);
            end
            for (int unsigned i = 0; i < 2; i++) begin
                if (busy[i] && ea[i]) busy[i] = 0;
                if (!busy[i]) begin
                    if ($urandom_range(2) == 0) begin
                        set_master(i, 1, $urandom, 1'($urandom), $urandom, 1'($urandom));
                        busy[i] = 1;
                    end else begin
                        set_master(i, 0, '0, 0, '0, 0);
                    end
                end
            end
            // memory output stays stable through the data phase
            if (m_slot != 2) bus.s_rdata = $urandom;
            model_step();
        end
        idle_inputs();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        do_reset();
        test_read();
        test_write();
        test_drop();
        test_lock_hold();
        test_alternate();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
